// File: rtl/game_state_ctrl.sv
// Game sequencer: MENU/PLAYING/DEAD/WIN state, lives, level, respawn and game-over pulses.
// Define GAME_TIMER_EN to enable the per-life countdown and timeout death.
module game_state_ctrl #(
   parameter int START_LIVES    = 3,
   parameter int MAX_LEVEL      = 9,
   parameter int TIME_LIMIT     = 60,
   parameter int FRAMES_PER_SEC = 60,
   parameter int DEAD_FRAMES    = 90,
   parameter int WIN_FRAMES     = 120,
   parameter int GUARD_CYCLES   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_btn,
   input  logic       frame_tick,
   input  logic       collision,
   input  logic       reached_end,
   output logic [1:0] state,
   output logic [2:0] lives,
   output logic [3:0] level,
   output logic [6:0] time_left,
   output logic       frog_respawn,
   output logic       game_over
);
   localparam logic [1:0] S_MENU = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_DEAD = 2'd2;
   localparam logic [1:0] S_WIN  = 2'd3;

   localparam int DWELL_MAX = (DEAD_FRAMES > WIN_FRAMES) ? DEAD_FRAMES : WIN_FRAMES;
   localparam int DW = $clog2(DWELL_MAX + 1);
   localparam int GW = $clog2(GUARD_CYCLES + 2);

   localparam logic [2:0]    LIVES_INIT = 3'(START_LIVES);
   localparam logic [3:0]    LEVEL_MAX  = 4'(MAX_LEVEL);
   localparam logic [6:0]    TIME_INIT  = 7'(TIME_LIMIT);
   localparam logic [DW-1:0] DEAD_INIT  = DW'(DEAD_FRAMES);
   localparam logic [DW-1:0] WIN_INIT   = DW'(WIN_FRAMES);
   localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD_CYCLES);

   logic [1:0]    state_q, state_d;
   logic [2:0]    lives_q, lives_d;
   logic [3:0]    level_q, level_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [GW-1:0] guard_q, guard_d;
   logic          respawn_q, respawn_d;
   logic          over_q, over_d;
   logic          start_q;
   logic          start_rise, hit, goal, timeout, enter_play;

`ifdef GAME_TIMER_EN
   localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);

   logic [6:0]    time_q, time_d;
   logic [FW-1:0] frame_q, frame_d;

   // time_left sits at 0 for one cycle before the timeout takes effect
   assign timeout   = (time_q == 7'd0);
   assign time_left = time_q;
`else
   assign timeout   = 1'b0;
   assign time_left = TIME_INIT;
`endif

   assign start_rise = start_btn & ~start_q;
   assign hit        = (guard_q == '0) & collision;
   assign goal       = (guard_q == '0) & reached_end;

   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      level_d    = level_q;
      dwell_d    = dwell_q;
      guard_d    = guard_q;
      respawn_d  = 1'b0;
      over_d     = 1'b0;
      enter_play = 1'b0;
`ifdef GAME_TIMER_EN
      time_d     = time_q;
      frame_d    = frame_q;
`endif
      case (state_q)
         S_MENU: begin
            if (start_rise) begin
               lives_d    = LIVES_INIT;
               level_d    = 4'd0;
               enter_play = 1'b1;
            end
         end
         S_PLAY: begin
            if (guard_q != '0) guard_d = guard_q - GW'(1);
            if (hit || (timeout && !goal)) begin
               state_d = S_DEAD;
               lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
               dwell_d = DEAD_INIT;
            end else if (goal) begin
               state_d = S_WIN;
               level_d = (level_q >= LEVEL_MAX) ? level_q : level_q + 4'd1;
               dwell_d = WIN_INIT;
            end
`ifdef GAME_TIMER_EN
            else if (frame_tick) begin
               if (frame_q == FRAME_LAST) begin
                  frame_d = '0;
                  time_d  = time_q - 7'd1;
               end else begin
                  frame_d = frame_q + FW'(1);
               end
            end
`endif
         end
         default: begin
            if (frame_tick) begin
               if (dwell_q > DW'(1)) begin
                  dwell_d = dwell_q - DW'(1);
               end else begin
                  dwell_d = '0;
                  if (state_q == S_DEAD && lives_q == 3'd0) begin
                     state_d = S_MENU;
                     over_d  = 1'b1;
                  end else begin
                     enter_play = 1'b1;
                  end
               end
            end
         end
      endcase
      // every entry into PLAYING restarts the life
      if (enter_play) begin
         state_d   = S_PLAY;
         respawn_d = 1'b1;
         guard_d   = GUARD_INIT;
`ifdef GAME_TIMER_EN
         time_d    = TIME_INIT;
         frame_d   = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_MENU;
         lives_q   <= LIVES_INIT;
         level_q   <= 4'd0;
         dwell_q   <= '0;
         guard_q   <= '0;
         respawn_q <= 1'b0;
         over_q    <= 1'b0;
         start_q   <= 1'b0;
`ifdef GAME_TIMER_EN
         time_q    <= TIME_INIT;
         frame_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         lives_q   <= lives_d;
         level_q   <= level_d;
         dwell_q   <= dwell_d;
         guard_q   <= guard_d;
         respawn_q <= respawn_d;
         over_q    <= over_d;
         start_q   <= start_btn;
`ifdef GAME_TIMER_EN
         time_q    <= time_d;
         frame_q   <= frame_d;
`endif
      end
   end

   assign state        = state_q;
   assign lives        = lives_q;
   assign level        = level_q;
   assign frog_respawn = respawn_q;
   assign game_over    = over_q;

endmodule
